// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS register window on the core
// data bus, a small byte FIFO and a start/data/stop shift FSM driving tx.
module uart_tx_mmio #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter logic [31:0] BASE_ADDR    = 32'h1001_0100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic        memread,
   input  logic [31:0] data_address,
   input  logic [31:0] writedata,
   output logic [31:0] received_data,
   output logic        hit,
   output logic        tx
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t              state_q, state_d;
   logic [BAUD_W-1:0]   baud_q, baud_d;
   logic [2:0]          idx_q, idx_d, nxt_idx;
   logic [7:0]          shift_q, shift_d;
   logic                tx_d;
   logic                pop;

   logic [7:0]          fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    rd_ptr, wr_ptr;
   logic [CNT_W-1:0]    count_q;
   logic                ovf_q;
   logic                full, empty, busy;
   logic                sel_status, wr_fire, push_req, push_ok, clr_ovf;
   logic [31:0]         status_word;
   logic                unused_bits;

   // memread and the byte-lane bits carry no meaning for this peripheral
   assign unused_bits = ^{memread, data_address[1:0], writedata[31:8]};

   // Bus decode
   assign hit        = (data_address[31:3] == BASE_ADDR[31:3]);
   assign sel_status = data_address[2];
   assign wr_fire    = memwrite && hit;
   assign push_req   = wr_fire && !sel_status;
   assign clr_ovf    = wr_fire && sel_status && writedata[3];

   assign full    = (count_q == CNT_FULL);
   assign empty   = (count_q == '0);
   assign busy    = (state_q != IDLE);
   assign push_ok = push_req && !full;

   assign status_word   = {20'd0, 4'(count_q), 4'd0, ovf_q, empty, full, busy};
   assign received_data = (hit && sel_status) ? status_word : 32'd0;

   // FIFO storage, no reset needed on the data array
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= writedata[7:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         // a dropped push sets overflow even if a pop frees a slot this edge
         if (push_req && full) ovf_q <= 1'b1;
         else if (clr_ovf)     ovf_q <= 1'b0;
      end
   end

   // TX FSM state register; tx is registered alongside the state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx      <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx      <= tx_d;
      end
   end

   // Next state; tx_d is the line level belonging to the next state
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      tx_d    = 1'b1;
      pop     = 1'b0;
      nxt_idx = idx_q + 3'd1;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = fifo_mem[rd_ptr];
               baud_d  = BAUD_MAX;
               state_d = START;
               tx_d    = 1'b0;
            end
         end
         START: begin
            tx_d = 1'b0;
            if (baud_q == '0) begin
               baud_d  = BAUD_MAX;
               idx_d   = 3'd0;
               state_d = DATA;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q - BAUD_W'(1);
            end
         end
         DATA: begin
            tx_d = shift_q[idx_q];
            if (baud_q == '0) begin
               baud_d = BAUD_MAX;
               if (idx_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  idx_d = nxt_idx;
                  tx_d  = shift_q[nxt_idx];
               end
            end else begin
               baud_d = baud_q - BAUD_W'(1);
            end
         end
         STOP: begin
            tx_d = 1'b1;
            if (baud_q == '0) begin
               // chain straight into the next start bit when data is waiting
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_mem[rd_ptr];
                  baud_d  = BAUD_MAX;
                  state_d = START;
                  tx_d    = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q - BAUD_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: frame-level reference model feeds an expected-frame
// queue that a line monitor drains as it decodes tx.
module tb_uart_tx_mmio;

   localparam int          CPB   = 4;
   localparam int          DEPTH = 4;
   localparam int          FRAME = 10 * CPB;
   localparam logic [31:0] BASE  = 32'h1001_0100;

   logic        clk = 1'b0;
   logic        reset;
   logic        memwrite;
   logic        memread;
   logic [31:0] data_address;
   logic [31:0] writedata;
   logic [31:0] received_data;
   logic        hit;
   logic        tx;

   uart_tx_mmio #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH),
      .BASE_ADDR   (BASE)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .memwrite     (memwrite),
      .memread      (memread),
      .data_address (data_address),
      .writedata    (writedata),
      .received_data(received_data),
      .hit          (hit),
      .tx           (tx)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         start;
      logic [7:0] data;
   } frame_t;

   int         checks   = 0;
   int         failures = 0;
   int         cyc      = 0;
   frame_t     exp_q[$];
   logic [7:0] mq[$];
   int         m_remain = 0;
   logic       m_ovf    = 1'b0;

   logic [FRAME-1:0] samp;
   int               nsamp    = 0;
   logic             in_frame = 1'b0;
   int               fstart   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic in_window(input logic [31:0] a);
      return a[31:3] == BASE[31:3];
   endfunction

   function automatic logic [31:0] exp_status();
      int n;
      n = mq.size();
      return {20'd0, 4'(n), 4'd0, m_ovf, n == 0, n == DEPTH, m_remain > 0};
   endfunction

   // Reference model: FIFO as a queue, transmitter as a 40-cycle frame timer
   always @(posedge clk or posedge reset) begin : model
      int     pre;
      logic   push_tx;
      frame_t f;
      if (reset) begin
         mq.delete();
         exp_q.delete();
         m_remain = 0;
         m_ovf    = 1'b0;
      end else begin
         cyc++;
         pre     = mq.size();
         push_tx = memwrite && in_window(data_address) && !data_address[2];
         if (memwrite && in_window(data_address) && data_address[2] && writedata[3]) m_ovf = 1'b0;
         if (push_tx && pre == DEPTH) m_ovf = 1'b1;
         if (pre > 0 && m_remain <= 1) begin
            f.start  = cyc;
            f.data   = mq.pop_front();
            exp_q.push_back(f);
            m_remain = FRAME;
         end else if (m_remain > 0) begin
            m_remain--;
         end
         if (push_tx && pre < DEPTH) mq.push_back(writedata[7:0]);
      end
   end

   // Line monitor: collect one frame of samples and compare with the scoreboard
   always @(negedge clk) begin : monitor
      frame_t           e;
      logic [FRAME-1:0] want;
      if (reset) begin
         in_frame = 1'b0;
         nsamp    = 0;
      end else if (!in_frame) begin
         if (tx === 1'b0) begin
            in_frame = 1'b1;
            fstart   = cyc;
            samp     = '1;
            samp[0]  = tx;
            nsamp    = 1;
         end
      end else begin
         samp[nsamp] = tx;
         nsamp++;
         if (nsamp == FRAME) begin
            in_frame = 1'b0;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_frame: got %h expected no frame", samp);
            end else begin
               e = exp_q.pop_front();
               for (int i = 0; i < FRAME; i++)
                  want[i] = (i < CPB) ? 1'b0 : (i >= 9 * CPB) ? 1'b1 : e.data[i / CPB - 1];
               checks++;
               if (samp !== want) begin
                  failures++;
                  $display("FAIL frame_wave: got %h expected %h (byte %h)", samp, want, e.data);
               end
               check("frame_start", 32'(fstart), 32'(e.start));
            end
         end
      end
   end

   task automatic bus_idle();
      @(negedge clk);
      memwrite     = 1'b0;
      memread      = 1'b0;
      data_address = 32'h0;
      writedata    = 32'h0;
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) bus_idle();
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      memwrite     = 1'b1;
      memread      = 1'b0;
      data_address = a;
      writedata    = d;
   endtask

   task automatic bus_read(input string name, input logic [31:0] a);
      @(negedge clk);
      memwrite     = 1'b0;
      memread      = 1'b1;
      data_address = a;
      writedata    = 32'h0;
      #1;
      check({name, "_hit"}, 32'(hit), 32'(in_window(a)));
      check({name, "_data"}, received_data, (in_window(a) && a[2]) ? exp_status() : 32'h0);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((mq.size() != 0 || m_remain != 0 || in_frame) && n < budget) begin
         bus_idle();
         n++;
      end
      check("drain_done", 32'(n < budget), 32'h1);
   endtask

   initial begin
      int op;
      reset        = 1'b1;
      memwrite     = 1'b0;
      memread      = 1'b0;
      data_address = 32'h0;
      writedata    = 32'h0;
      repeat (3) @(negedge clk);
      check("tx_in_reset", 32'(tx), 32'h1);
      reset = 1'b0;

      // reset state
      bus_read("t1_status", BASE + 32'h4);
      check("t1_literal", received_data, 32'h4);
      check("t1_tx", 32'(tx), 32'h1);

      // single frame
      bus_write(BASE, 32'h55);
      bus_read("t2_after_write", BASE + 32'h4);
      wait_cycles(20);
      bus_read("t2_mid", BASE + 32'h4);
      check("t2_mid_literal", received_data, 32'h5);
      wait_cycles(25);
      bus_read("t2_end", BASE + 32'h4);
      check("t2_end_literal", received_data, 32'h4);

      // fill FIFO, overflow, back-to-back frames
      for (int i = 0; i < 6; i++) bus_write(BASE, 32'hA0 + 32'(i));
      bus_read("t3_status", BASE + 32'h4);
      check("t3_literal", received_data, 32'h0000_040B);
      drain(600);

      // overflow clear
      bus_read("t4_ovf", BASE + 32'h4);
      check("t4_ovf_literal", received_data, 32'hC);
      bus_write(BASE + 32'h4, 32'h0);
      bus_read("t4_nop", BASE + 32'h4);
      check("t4_nop_literal", received_data, 32'hC);
      bus_write(BASE + 32'h4, 32'h8);
      bus_read("t4_clr", BASE + 32'h4);
      check("t4_clr_literal", received_data, 32'h4);

      // reset mid-frame
      bus_write(BASE, 32'hFF);
      bus_idle();
      wait_cycles(14);
      bus_read("t5_busy", BASE + 32'h4);
      check("t5_busy_literal", received_data, 32'h5);
      #2 reset = 1'b1;
      #1 check("t5_tx_async", 32'(tx), 32'h1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      bus_read("t5_status", BASE + 32'h4);
      check("t5_literal", received_data, 32'h4);
      wait_cycles(50);
      check("t5_tx_quiet", 32'(tx), 32'h1);

      // out-of-window access
      bus_write(BASE + 32'h10, 32'h12);
      bus_read("t6_miss", BASE + 32'h10);
      check("t6_hit_literal", 32'(hit), 32'h0);
      check("t6_data_literal", received_data, 32'h0);
      bus_read("t6_status", BASE + 32'h4);
      check("t6_literal", received_data, 32'h4);
      check("t6_tx", 32'(tx), 32'h1);

      // randomized traffic
      for (int k = 0; k < 120; k++) begin
         op = int'($urandom_range(0, 9));
         if (op <= 4)      bus_write(BASE + 32'($urandom_range(0, 3)), $urandom());
         else if (op <= 6) bus_read("rnd_read", BASE + 32'($urandom_range(0, 7)));
         else if (op == 7) bus_write(BASE + 32'h4 + 32'($urandom_range(0, 3)), $urandom());
         else if (op == 8) bus_write($urandom(), $urandom());
         else              wait_cycles(int'($urandom_range(1, 60)));
      end
      drain(2000);
      bus_read("final_status", BASE + 32'h4);
      check("frames_left", 32'(exp_q.size()), 32'h0);
      check("final_tx", 32'(tx), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
